// File: rtl/if_id_stage_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, reset/flush constants
// and the target-alignment helper.
package if_id_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_id_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (output imem_addr, output imem_req,
                  input  imem_rdata, input imem_ack);
  modport slave  (input  imem_addr, input imem_req,
                  output imem_rdata, output imem_ack);
endinterface

// File: rtl/if_id_stage_hazard_detect.sv
// Load-use hazard compare: a load in ID/EX whose destination feeds a source of IF/ID.
module hazard_detect (
  input  logic       valid_i,
  input  logic       mem_to_reg_i,
  input  logic [4:0] ld_rd_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       hazard_o
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard_o = valid_i && mem_to_reg_i && (ld_rd_i != 5'd0) &&
                    ((ld_rd_i == rs_i) || (ld_rd_i == rt_i));

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage with IF/ID register: one outstanding imem request, one-entry skid
// buffer for words that land during a load-use stall, and redirect flushing.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_id_stage_if.master         imem,
  input  logic                  redirect_br,
  input  logic [31:0]           br_target,
  input  logic                  redirect_jmp,
  input  logic [31:0]           jmp_target,
  input  logic                  idex_MemtoReg,
  input  logic [4:0]            idex_rt,
  output logic [31:0]           newPC_f,
  output logic [31:0]           Inst_f,
  output logic                  valid_f,
  output logic                  stall,
  output logic                  idex_clr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;
  logic [31:0]  skid_inst_q, skid_inst_d;
  logic [31:0]  skid_npc_q, skid_npc_d;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_inc;

  assign redirect = redirect_br | redirect_jmp;
  assign target   = align_word(redirect_jmp ? jmp_target : br_target);
  assign pc_inc   = pc_q + 32'd4;

  hazard_detect u_hazard (
    .valid_i      (valid_q),
    .mem_to_reg_i (idex_MemtoReg),
    .ld_rd_i      (idex_rt),
    .rs_i         (inst_q[25:21]),
    .rt_i         (inst_q[20:16]),
    .hazard_o     (stall)
  );

  assign idex_clr = stall | redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect) begin
      // A request still in flight (FETCH or DROP, no ack now) must have its reply swallowed
      state_d = ((state_q != HOLD) && !imem.imem_ack) ? DROP : FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (imem.imem_ack && stall) state_d = HOLD;
        HOLD:    if (!stall)                 state_d = FETCH;
        DROP:    if (imem.imem_ack)          state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_comb begin
    imem.imem_req  = (state_q == FETCH);
    imem.imem_addr = pc_q;
  end

  always_comb begin
    pc_d        = pc_q;
    inst_d      = inst_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    skid_inst_d = skid_inst_q;
    skid_npc_d  = skid_npc_q;
    if (redirect) begin
      pc_d        = target;
      inst_d      = NOP_INST;
      npc_d       = 32'd0;
      valid_d     = 1'b0;
      skid_inst_d = NOP_INST;
      skid_npc_d  = 32'd0;
    end else begin
      unique case (state_q)
        FETCH: if (imem.imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            skid_inst_d = imem.imem_rdata;
            skid_npc_d  = pc_inc;
          end else begin
            inst_d  = imem.imem_rdata;
            npc_d   = pc_inc;
            valid_d = 1'b1;
          end
        end
        HOLD: if (!stall) begin
          inst_d  = skid_inst_q;
          npc_d   = skid_npc_q;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      npc_q       <= 32'd0;
      valid_q     <= 1'b0;
      skid_inst_q <= NOP_INST;
      skid_npc_q  <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
      skid_inst_q <= skid_inst_d;
      skid_npc_q  <= skid_npc_d;
    end
  end

  assign newPC_f = npc_q;
  assign Inst_f  = inst_q;
  assign valid_f = valid_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  RESET_PC  32'h0000_0000  PC loaded on reset
  NOP_INST  32'h0000_0000  instruction word written into IF/ID on flush/reset
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk            in   1   single clock, all state on posedge
  rst_n          in   1   reset, asynchronous, active-low
  imem_addr      out  32  fetch address (current PC)
  imem_req       out  1   fetch request
  imem_rdata     in   32  fetched word, valid when imem_ack=1
  imem_ack       in   1   1-cycle completion pulse for the oldest outstanding request
  redirect_br    in   1   taken branch resolved in EX
  br_target      in   32  branch target
  redirect_jmp   in   1   jump resolved in EX
  jmp_target     in   32  jump target
  idex_MemtoReg  in   1   instruction in ID/EX is a load
  idex_rt        in   5   load destination register in ID/EX
  newPC_f        out  32  PC+4 of the instruction held in IF/ID
  Inst_f         out  32  instruction held in IF/ID
  valid_f        out  1   IF/ID holds a real instruction
  stall          out  1   load-use stall asserted this cycle
  idex_clr       out  1   bubble request to the ID/EX register (its clr input)

Function
REQ-003 FSM states SHALL be FETCH, HOLD and DROP.
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; at most one request SHALL be outstanding.
REQ-005 FETCH with imem_ack=1, no stall and no redirect: on the next edge Inst_f<=imem_rdata, newPC_f<=PC+4, valid_f<=1, PC<=PC+4; stay in FETCH.
REQ-006 FETCH with imem_ack=1 and stall=1: capture imem_rdata and PC+4 into a one-entry skid buffer, PC<=PC+4, go to HOLD; IF/ID unchanged.
REQ-007 In HOLD, imem_req SHALL be 0; when stall=0, the skid buffer SHALL move into IF/ID on the next edge and the state SHALL return to FETCH.
REQ-008 FETCH with no imem_ack and stall=1: IF/ID SHALL hold its value and the request SHALL stay asserted.
REQ-009 stall SHALL be combinational: valid_f & idex_MemtoReg & (idex_rt!=0) & (idex_rt==Inst_f[25:21] | idex_rt==Inst_f[20:16]).
REQ-010 A redirect (redirect_br|redirect_jmp) SHALL take priority over stall and ack. On the next edge: PC<=target, Inst_f<=NOP_INST, valid_f<=0, newPC_f<=0, skid buffer emptied.
REQ-011 If a request is outstanding at the redirect (FETCH, no ack the same cycle), the state SHALL go to DROP; otherwise it SHALL go to FETCH.
REQ-012 In DROP, imem_req SHALL be 0; the next imem_ack SHALL be discarded and the state SHALL return to FETCH on the following edge.
REQ-013 When redirect_jmp and redirect_br are both 1, jmp_target SHALL be used.
REQ-014 idex_clr SHALL be combinational: stall | redirect_br | redirect_jmp.
REQ-015 PC arithmetic SHALL be modulo 2^32: PC 32'hFFFF_FFFC increments to 0. Bits [1:0] of the targets SHALL be forced to 0.
REQ-016 Fetch-to-IF/ID latency SHALL be one edge after imem_ack (zero-wait memory gives one instruction per cycle).

Reset
REQ-017 While rst_n=0: PC=RESET_PC, state=FETCH, Inst_f=NOP_INST, newPC_f=0, valid_f=0, skid buffer empty.
REQ-018 Reset mid-request SHALL NOT wait for the pending ack. The first imem_ack after release SHALL be treated as the reply to the new request at RESET_PC.

Structure
REQ-019 The FSM state encoding, RESET_PC and NOP_INST SHALL live in the shared pipeline package.
REQ-020 The block SHALL include one sub-module, hazard_detect, containing the REQ-009 compare logic (reusable by the forwarding unit).

Verification
REQ-021 Reset then ack every cycle with words I0..I3 -> imem_addr 0,4,8,12 on consecutive cycles; Inst_f=I0 with newPC_f=4 one edge after the first ack.
REQ-022 Load in ID/EX (idex_MemtoReg=1, idex_rt=8) and Inst_f rs=8 -> stall=1 and idex_clr=1 for exactly that cycle; the word acked during the stall appears in Inst_f one edge after stall drops.
REQ-023 Load with idex_rt=0 matching Inst_f rs=0 -> stall=0.
REQ-024 redirect_br=1 with br_target=32'h100 while a request is unacked -> Inst_f=0, valid_f=0, idex_clr=1; the next ack is dropped; the next imem_addr is 32'h100.
REQ-025 redirect_br and redirect_jmp together with targets 32'h200/32'h300 -> PC=32'h300; both targets 32'h203 -> PC=32'h200 (bits [1:0] cleared).
REQ-026 rst_n pulsed low during HOLD -> all outputs at REQ-017 values asynchronously; fetch resumes at 0.
